// File: rtl/mist1032sa_arbiter_response_router_pkg.sv
// Shared types for the MIST1032SA memory-bus arbiters: master ID encoding and
// the outstanding-request tag record. Wider arbiters reuse these.
package mist1032sa_arbiter_response_router_pkg;

    typedef enum logic {
        MASTER_M0 = 1'b0,
        MASTER_M1 = 1'b1
    } master_id_t;

    // One outstanding request: valid=0 marks a flushed entry whose response is dropped.
    typedef struct packed {
        logic       valid;
        master_id_t id;
    } tag_t;

    function automatic master_id_t other_master(input master_id_t id);
        return (id == MASTER_M0) ? MASTER_M1 : MASTER_M0;
    endfunction

endpackage

// File: rtl/mist1032sa_arbiter_tag_fifo.sv
// In-order tag FIFO recording which master owns each outstanding bus request.
// flash clears every valid bit but keeps the pointers, so flushed responses still pop.
module mist1032sa_arbiter_tag_fifo
    import mist1032sa_arbiter_response_router_pkg::*;
#(
    parameter int D  = 8,
    parameter int DN = 3
)(
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       flash,
    input  logic       push,
    input  master_id_t push_id,
    input  logic       pop,
    output tag_t       head,
    output logic       full,
    output logic       empty
);

    logic [DN:0]  wr_ptr;
    logic [DN:0]  rd_ptr;
    logic [DN:0]  count;
    logic [D-1:0] valid_q;
    master_id_t   id_q [D];

    // One extra pointer bit distinguishes full from empty; count never exceeds D.
    assign count = wr_ptr - rd_ptr;
    assign full  = count[DN];
    assign empty = (count == '0);

    assign head.valid = valid_q[rd_ptr[DN-1:0]];
    assign head.id    = id_q[rd_ptr[DN-1:0]];

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!inRESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (DN+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (DN+1)'(1);
            if (flash)     valid_q <= '0;
            else if (push) valid_q[wr_ptr[DN-1:0]] <= 1'b1;
        end
    end

    // NOTE: the id array is left unreset; an id is only read behind a valid bit that is reset.
    always_ff @(posedge iCLOCK) begin
        if (push) id_q[wr_ptr[DN-1:0]] <= push_id;
    end

endmodule

// File: rtl/mist1032sa_arbiter_response_router.sv
// Two-master round-robin request arbiter for the shared memory bus, steering each
// in-order response back to the master that issued the request.
module mist1032sa_arbiter_response_router
    import mist1032sa_arbiter_response_router_pkg::*;
#(
    parameter int D  = 8,
    parameter int DN = 3,
    parameter int AW = 32,
    parameter int DW = 32
)(
    input  logic          iCLOCK,
    input  logic          inRESET,
    input  logic          iFLASH,
    input  logic          iM0_REQ,
    output logic          oM0_BUSY,
    input  logic          iM0_RW,
    input  logic [AW-1:0] iM0_ADDR,
    input  logic [DW-1:0] iM0_DATA,
    output logic          oM0_VALID,
    output logic [DW-1:0] oM0_DATA,
    input  logic          iM1_REQ,
    output logic          oM1_BUSY,
    input  logic          iM1_RW,
    input  logic [AW-1:0] iM1_ADDR,
    input  logic [DW-1:0] iM1_DATA,
    output logic          oM1_VALID,
    output logic [DW-1:0] oM1_DATA,
    output logic          oMEM_REQ,
    input  logic          iMEM_BUSY,
    output logic          oMEM_RW,
    output logic [AW-1:0] oMEM_ADDR,
    output logic [DW-1:0] oMEM_DATA,
    input  logic          iMEM_VALID,
    input  logic [DW-1:0] iMEM_DATA
);

    master_id_t last_grant;
    master_id_t granted;
    logic       tag_full;
    logic       tag_empty;
    logic       accepted;
    logic       pop;
    logic       deliver;
    tag_t       head;

    always_comb begin
        // NOTE: default first so every path assigns granted and no latch is inferred.
        granted = MASTER_M0;
        if (iM0_REQ && iM1_REQ) granted = other_master(last_grant);
        else if (iM1_REQ)       granted = MASTER_M1;
    end

    assign oMEM_REQ  = (iM0_REQ || iM1_REQ) && !tag_full && !iFLASH;
    assign oMEM_RW   = (granted == MASTER_M1) ? iM1_RW   : iM0_RW;
    assign oMEM_ADDR = (granted == MASTER_M1) ? iM1_ADDR : iM0_ADDR;
    assign oMEM_DATA = (granted == MASTER_M1) ? iM1_DATA : iM0_DATA;

    assign accepted = oMEM_REQ && !iMEM_BUSY;
    assign oM0_BUSY = iM0_REQ && !(accepted && granted == MASTER_M0);
    assign oM1_BUSY = iM1_REQ && !(accepted && granted == MASTER_M1);

    // A response arriving with no outstanding tag is stray and leaves the FIFO alone.
    assign pop     = iMEM_VALID && !tag_empty;
    assign deliver = pop && head.valid && !iFLASH;

    mist1032sa_arbiter_tag_fifo #(
        .D  (D),
        .DN (DN)
    ) u_tag_fifo (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .flash   (iFLASH),
        .push    (accepted),
        .push_id (granted),
        .pop     (pop),
        .head    (head),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    // Reset to M1 so M0 wins the first tie.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET)      last_grant <= MASTER_M1;
        else if (accepted) last_grant <= granted;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oM0_VALID <= 1'b0;
            oM1_VALID <= 1'b0;
            oM0_DATA  <= '0;
            oM1_DATA  <= '0;
        end else begin
            oM0_VALID <= deliver && (head.id == MASTER_M0);
            oM1_VALID <= deliver && (head.id == MASTER_M1);
            if (deliver && head.id == MASTER_M0) oM0_DATA <= iMEM_DATA;
            if (deliver && head.id == MASTER_M1) oM1_DATA <= iMEM_DATA;
        end
    end

endmodule

// File: tb/tb_mist1032sa_arbiter_response_router.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// queue-based reference model of grant order and response ownership.
`timescale 1ns/1ps
module tb_mist1032sa_arbiter_response_router;

    localparam int D  = 8;
    localparam int DN = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          iCLOCK = 1'b0;
    logic          inRESET = 1'b0;
    logic          iFLASH, iMEM_BUSY, iMEM_VALID;
    logic          iM0_REQ, iM0_RW, iM1_REQ, iM1_RW;
    logic [AW-1:0] iM0_ADDR, iM1_ADDR;
    logic [DW-1:0] iM0_DATA, iM1_DATA, iMEM_DATA;
    logic          oM0_BUSY, oM1_BUSY, oM0_VALID, oM1_VALID;
    logic [DW-1:0] oM0_DATA, oM1_DATA;
    logic          oMEM_REQ, oMEM_RW;
    logic [AW-1:0] oMEM_ADDR;
    logic [DW-1:0] oMEM_DATA;

    mist1032sa_arbiter_response_router #(.D(D), .DN(DN), .AW(AW), .DW(DW)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iFLASH(iFLASH),
        .iM0_REQ(iM0_REQ), .oM0_BUSY(oM0_BUSY), .iM0_RW(iM0_RW), .iM0_ADDR(iM0_ADDR),
        .iM0_DATA(iM0_DATA), .oM0_VALID(oM0_VALID), .oM0_DATA(oM0_DATA),
        .iM1_REQ(iM1_REQ), .oM1_BUSY(oM1_BUSY), .iM1_RW(iM1_RW), .iM1_ADDR(iM1_ADDR),
        .iM1_DATA(iM1_DATA), .oM1_VALID(oM1_VALID), .oM1_DATA(oM1_DATA),
        .oMEM_REQ(oMEM_REQ), .iMEM_BUSY(iMEM_BUSY), .oMEM_RW(oMEM_RW),
        .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
        .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: outstanding requests as a queue of owners (2 = flushed).
    int            exp_q[$];
    int            ref_last = 1;
    logic          exp_v [2];
    logic [DW-1:0] exp_d [2];

    function automatic int ref_grant();
        if (iM0_REQ && iM1_REQ) return (ref_last == 1) ? 0 : 1;
        return iM1_REQ ? 1 : 0;
    endfunction

    function automatic bit ref_mem_req();
        return (iM0_REQ || iM1_REQ) && exp_q.size() < D && !iFLASH;
    endfunction

    function automatic bit ref_busy(int m);
        bit req = (m == 0) ? iM0_REQ : iM1_REQ;
        return req && !(ref_mem_req() && !iMEM_BUSY && ref_grant() == m);
    endfunction

    task automatic ref_reset();
        exp_q.delete();
        ref_last = 1;
        exp_v[0] = 1'b0; exp_v[1] = 1'b0;
        exp_d[0] = '0;   exp_d[1] = '0;
    endtask

    task automatic idle();
        iFLASH = 1'b0; iMEM_BUSY = 1'b0; iMEM_VALID = 1'b0;
        iM0_REQ = 1'b0; iM1_REQ = 1'b0; iM0_RW = 1'b0; iM1_RW = 1'b0;
    endtask

    // Advance one clock from a negedge to the next, updating the model at the edge.
    task automatic tick();
        bit            acc = ref_mem_req() && !iMEM_BUSY;
        int            g   = ref_grant();
        bit            pop = iMEM_VALID && exp_q.size() > 0;
        bit            fl  = iFLASH;
        logic [DW-1:0] d   = iMEM_DATA;
        @(posedge iCLOCK);
        exp_v[0] = 1'b0; exp_v[1] = 1'b0;
        if (pop) begin
            int h = exp_q.pop_front();
            if (h != 2 && !fl) begin
                exp_v[h] = 1'b1;
                exp_d[h] = d;
            end
        end
        if (fl) foreach (exp_q[i]) exp_q[i] = 2;
        if (acc) begin
            exp_q.push_back(g);
            ref_last = g;
        end
        @(negedge iCLOCK);
    endtask

    task automatic test_reset();
        idle();
        #1;
        n_vec++;
        if ({oM0_VALID, oM1_VALID, oMEM_REQ, oM0_BUSY, oM1_BUSY} !== 5'b0 || oM0_DATA !== '0 || oM1_DATA !== '0) begin
            n_err++;
            $display("FAIL reset: valid=%b%b req=%b busy=%b%b data=%h/%h, want all 0",
                     oM0_VALID, oM1_VALID, oMEM_REQ, oM0_BUSY, oM1_BUSY, oM0_DATA, oM1_DATA);
        end
        tick();
    endtask

    task automatic test_tie_round_robin();
        logic [DW-1:0] rd [4];
        logic [AW-1:0] a0, a1;
        a0 = AW'($urandom);
        a1 = ~a0;
        iM0_ADDR = a0; iM1_ADDR = a1; iM0_RW = 1'b1; iM1_RW = 1'b0;
        iM0_DATA = DW'($urandom); iM1_DATA = DW'($urandom);
        iM0_REQ = 1'b1; iM1_REQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (oMEM_REQ !== 1'b1 || oMEM_ADDR !== ((i % 2) ? a1 : a0) || oMEM_RW !== (i % 2 == 0) ||
                {oM0_BUSY, oM1_BUSY} !== ((i % 2) ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL tie_grant %0d: req=%b addr=%h rw=%b busy=%b%b, want grant M%0d", i,
                         oMEM_REQ, oMEM_ADDR, oMEM_RW, oM0_BUSY, oM1_BUSY, i % 2);
            end
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            iMEM_VALID = 1'b1;
            iMEM_DATA = DW'($urandom);
            rd[i] = iMEM_DATA;
            tick();
            n_vec++;
            if ({oM0_VALID, oM1_VALID} !== ((i % 2) ? 2'b01 : 2'b10) ||
                ((i % 2) ? oM1_DATA : oM0_DATA) !== rd[i]) begin
                n_err++;
                $display("FAIL tie_resp %0d: valid=%b%b data=%h/%h, want M%0d data %h", i,
                         oM0_VALID, oM1_VALID, oM0_DATA, oM1_DATA, i % 2, rd[i]);
            end
        end
        iMEM_VALID = 1'b0;
        tick();
    endtask

    task automatic test_full();
        logic [DW-1:0] d;
        idle();
        iM0_REQ = 1'b1;
        for (int i = 0; i < D; i++) begin
            iM0_ADDR = AW'($urandom);
            #1;
            n_vec++;
            if (oMEM_REQ !== 1'b1 || oM0_BUSY !== 1'b0 || oMEM_ADDR !== iM0_ADDR) begin
                n_err++;
                $display("FAIL full_fill %0d: req=%b busy=%b addr=%h, want 1 0 %h", i, oMEM_REQ, oM0_BUSY, oMEM_ADDR, iM0_ADDR);
            end
            tick();
        end
        iM0_ADDR = AW'($urandom);
        #1;
        n_vec++;
        if (oMEM_REQ !== 1'b0 || oM0_BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL full_block: req=%b busy=%b, want 0 1", oMEM_REQ, oM0_BUSY);
        end
        iMEM_VALID = 1'b1;
        iMEM_DATA = DW'($urandom);
        d = iMEM_DATA;
        #1;
        n_vec++;
        if (oMEM_REQ !== 1'b0 || oM0_BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL full_pop_no_push: req=%b busy=%b, want 0 1", oMEM_REQ, oM0_BUSY);
        end
        tick();
        iMEM_VALID = 1'b0;
        n_vec++;
        if ({oM0_VALID, oM1_VALID} !== 2'b10 || oM0_DATA !== d) begin
            n_err++;
            $display("FAIL full_resp: valid=%b%b data=%h, want 10 %h", oM0_VALID, oM1_VALID, oM0_DATA, d);
        end
        #1;
        n_vec++;
        if (oMEM_REQ !== 1'b1 || oM0_BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL full_freed: req=%b busy=%b, want 1 0", oMEM_REQ, oM0_BUSY);
        end
        tick();
        idle();
        for (int i = 0; i < D; i++) begin
            iMEM_VALID = 1'b1;
            iMEM_DATA = DW'($urandom);
            d = iMEM_DATA;
            tick();
            n_vec++;
            if ({oM0_VALID, oM1_VALID} !== 2'b10 || oM0_DATA !== d) begin
                n_err++;
                $display("FAIL full_drain %0d: valid=%b%b data=%h, want 10 %h", i, oM0_VALID, oM1_VALID, oM0_DATA, d);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_flash();
        int            order [3] = '{1, 0, 1};
        logic [DW-1:0] d;
        idle();
        for (int i = 0; i < 3; i++) begin
            iM0_REQ = (order[i] == 0);
            iM1_REQ = (order[i] == 1);
            tick();
        end
        idle();
        iM0_REQ = 1'b1;
        iM0_ADDR = AW'($urandom);
        iFLASH = 1'b1;
        #1;
        n_vec++;
        if (oMEM_REQ !== 1'b0 || oM0_BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL flash_block: req=%b busy=%b, want 0 1", oMEM_REQ, oM0_BUSY);
        end
        tick();
        iFLASH = 1'b0;
        #1;
        n_vec++;
        if (oMEM_REQ !== 1'b1 || oM0_BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL flash_next_req: req=%b busy=%b, want 1 0", oMEM_REQ, oM0_BUSY);
        end
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            iMEM_VALID = 1'b1;
            iMEM_DATA = DW'($urandom);
            d = iMEM_DATA;
            tick();
            n_vec++;
            if (i < 3 && {oM0_VALID, oM1_VALID} !== 2'b00) begin
                n_err++;
                $display("FAIL flash_drop %0d: valid=%b%b, want 00", i, oM0_VALID, oM1_VALID);
            end else if (i == 3 && ({oM0_VALID, oM1_VALID} !== 2'b10 || oM0_DATA !== d)) begin
                n_err++;
                $display("FAIL flash_after: valid=%b%b data=%h, want 10 %h", oM0_VALID, oM1_VALID, oM0_DATA, d);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_push_pop();
        int            own [5];
        logic [DW-1:0] d;
        idle();
        for (int i = 0; i < 4; i++) begin
            own[i] = int'($urandom_range(0, 1));
            iM0_REQ = (own[i] == 0);
            iM1_REQ = (own[i] == 1);
            tick();
        end
        own[4] = 1;
        iM0_REQ = 1'b0; iM1_REQ = 1'b1;
        iMEM_VALID = 1'b1;
        iMEM_DATA = DW'($urandom);
        d = iMEM_DATA;
        #1;
        n_vec++;
        if (oMEM_REQ !== 1'b1 || oM1_BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL pushpop_accept: req=%b busy=%b, want 1 0", oMEM_REQ, oM1_BUSY);
        end
        tick();
        n_vec++;
        if ({oM0_VALID, oM1_VALID} !== (own[0] ? 2'b01 : 2'b10) || (own[0] ? oM1_DATA : oM0_DATA) !== d) begin
            n_err++;
            $display("FAIL pushpop_resp: valid=%b%b data=%h/%h, want M%0d %h", oM0_VALID, oM1_VALID, oM0_DATA, oM1_DATA, own[0], d);
        end
        idle();
        for (int i = 1; i < 6; i++) begin
            iMEM_VALID = 1'b1;
            iMEM_DATA = DW'($urandom);
            d = iMEM_DATA;
            tick();
            n_vec++;
            if (i == 5 && {oM0_VALID, oM1_VALID} !== 2'b00) begin
                n_err++;
                $display("FAIL pushpop_count: valid=%b%b after 4 drained, want 00", oM0_VALID, oM1_VALID);
            end else if (i < 5 && ({oM0_VALID, oM1_VALID} !== (own[i] ? 2'b01 : 2'b10) ||
                                   (own[i] ? oM1_DATA : oM0_DATA) !== d)) begin
                n_err++;
                $display("FAIL pushpop_drain %0d: valid=%b%b data=%h/%h, want M%0d %h", i,
                         oM0_VALID, oM1_VALID, oM0_DATA, oM1_DATA, own[i], d);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_stray_busy();
        logic [DW-1:0] d;
        idle();
        iMEM_VALID = 1'b1;
        iMEM_DATA = DW'($urandom);
        tick();
        n_vec++;
        if ({oM0_VALID, oM1_VALID} !== 2'b00) begin
            n_err++;
            $display("FAIL stray: valid=%b%b, want 00", oM0_VALID, oM1_VALID);
        end
        idle();
        iM1_REQ = 1'b1;
        iM1_ADDR = AW'($urandom);
        iMEM_BUSY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if (oMEM_REQ !== 1'b1 || oM1_BUSY !== 1'b1 || oMEM_ADDR !== iM1_ADDR) begin
                n_err++;
                $display("FAIL bus_busy %0d: req=%b busy=%b addr=%h, want 1 1 %h", i, oMEM_REQ, oM1_BUSY, oMEM_ADDR, iM1_ADDR);
            end
            tick();
        end
        iMEM_BUSY = 1'b0;
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            iMEM_VALID = 1'b1;
            iMEM_DATA = DW'($urandom);
            d = iMEM_DATA;
            tick();
            n_vec++;
            if ({oM0_VALID, oM1_VALID} !== ((i == 0) ? 2'b01 : 2'b00) || (i == 0 && oM1_DATA !== d)) begin
                n_err++;
                $display("FAIL busy_nopush %0d: valid=%b%b data=%h, want %s", i, oM0_VALID, oM1_VALID, oM1_DATA,
                         (i == 0) ? "M1 response" : "none");
            end
        end
        idle();
        tick();
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d;
        idle();
        for (int i = 0; i < 20; i++) begin
            iM0_REQ = (i % 2 == 0);
            iM1_REQ = (i % 2 == 1);
            tick();
            idle();
            iMEM_VALID = 1'b1;
            iMEM_DATA = DW'($urandom);
            d = iMEM_DATA;
            tick();
            n_vec++;
            if ({oM0_VALID, oM1_VALID} !== ((i % 2) ? 2'b01 : 2'b10) || ((i % 2) ? oM1_DATA : oM0_DATA) !== d) begin
                n_err++;
                $display("FAIL wrap %0d: valid=%b%b data=%h/%h, want M%0d %h", i, oM0_VALID, oM1_VALID, oM0_DATA, oM1_DATA, i % 2, d);
            end
            idle();
        end
        tick();
    endtask

    task automatic test_random(int cycles);
        bit            hold0 = 1'b0;
        bit            hold1 = 1'b0;
        int            g;
        logic [AW-1:0] want_addr;
        logic [DW-1:0] want_data;
        logic          want_rw;
        for (int c = 0; c < cycles + 2 * D; c++) begin
            if (!hold0) begin
                iM0_REQ = (c < cycles) && ($urandom_range(0, 3) != 0);
                iM0_RW = 1'($urandom_range(0, 1)); iM0_ADDR = AW'($urandom); iM0_DATA = DW'($urandom);
            end
            if (!hold1) begin
                iM1_REQ = (c < cycles) && ($urandom_range(0, 3) != 0);
                iM1_RW = 1'($urandom_range(0, 1)); iM1_ADDR = AW'($urandom); iM1_DATA = DW'($urandom);
            end
            iMEM_BUSY  = ($urandom_range(0, 3) == 0);
            iMEM_VALID = (c >= cycles) || ($urandom_range(0, 1) == 1);
            iMEM_DATA  = DW'($urandom);
            iFLASH     = (c < cycles) && ($urandom_range(0, 31) == 0);
            #1;
            g = ref_grant();
            want_addr = g ? iM1_ADDR : iM0_ADDR;
            want_data = g ? iM1_DATA : iM0_DATA;
            want_rw   = g ? iM1_RW : iM0_RW;
            n_vec++;
            if ({oMEM_REQ, oM0_BUSY, oM1_BUSY} !== {ref_mem_req(), ref_busy(0), ref_busy(1)} ||
                (ref_mem_req() && {oMEM_RW, oMEM_ADDR, oMEM_DATA} !== {want_rw, want_addr, want_data})) begin
                n_err++;
                $display("FAIL rand_req %0d: req=%b busy=%b%b rw=%b addr=%h, want %b %b%b %b %h", c,
                         oMEM_REQ, oM0_BUSY, oM1_BUSY, oMEM_RW, oMEM_ADDR,
                         ref_mem_req(), ref_busy(0), ref_busy(1), want_rw, want_addr);
            end
            hold0 = ref_busy(0);
            hold1 = ref_busy(1);
            tick();
            n_vec++;
            if (oM0_VALID !== exp_v[0] || oM1_VALID !== exp_v[1] || oM0_DATA !== exp_d[0] || oM1_DATA !== exp_d[1]) begin
                n_err++;
                $display("FAIL rand_resp %0d: valid=%b%b data=%h/%h, want %b%b %h/%h", c, oM0_VALID, oM1_VALID,
                         oM0_DATA, oM1_DATA, exp_v[0], exp_v[1], exp_d[0], exp_d[1]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        iM0_REQ = 1'b1; tick();
        idle(); iM1_REQ = 1'b1; tick();
        idle(); iMEM_VALID = 1'b1; iMEM_DATA = DW'($urandom); tick();
        idle();
        #1 inRESET = 1'b0;
        #1;
        n_vec++;
        if ({oM0_VALID, oM1_VALID} !== 2'b00 || oM0_DATA !== '0 || oM1_DATA !== '0) begin
            n_err++;
            $display("FAIL reset_async: valid=%b%b data=%h/%h, want 00 0/0", oM0_VALID, oM1_VALID, oM0_DATA, oM1_DATA);
        end
        ref_reset();
        @(negedge iCLOCK);
        inRESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            iMEM_VALID = 1'b1;
            iMEM_DATA = DW'($urandom);
            tick();
            n_vec++;
            if ({oM0_VALID, oM1_VALID} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_stray %0d: valid=%b%b, want 00", i, oM0_VALID, oM1_VALID);
            end
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        iM0_ADDR = '0; iM1_ADDR = '0; iM0_DATA = '0; iM1_DATA = '0; iMEM_DATA = '0;
        ref_reset();
        inRESET = 1'b0;
        repeat (2) @(negedge iCLOCK);
        inRESET = 1'b1;
        test_reset();
        test_tie_round_robin();
        test_full();
        test_flash();
        test_push_pop();
        test_stray_busy();
        test_wrap();
        test_random(400);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
